// File: rtl/idct8_pipe.sv
// HEVC partial-butterfly inverse DCT, 8-point or 4-point per vector, three-stage
// stallable pipeline with valid/ready handshake, round-and-shift and output saturation.
module idct8_pipe #(
  parameter int WIDTH_X = 16,
  parameter int WIDTH_Y = 16,
  parameter int SHIFT   = 7
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode,
  input  logic signed [WIDTH_X-1:0] x0,
  input  logic signed [WIDTH_X-1:0] x1,
  input  logic signed [WIDTH_X-1:0] x2,
  input  logic signed [WIDTH_X-1:0] x3,
  input  logic signed [WIDTH_X-1:0] x4,
  input  logic signed [WIDTH_X-1:0] x5,
  input  logic signed [WIDTH_X-1:0] x6,
  input  logic signed [WIDTH_X-1:0] x7,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH_Y-1:0] y0,
  output logic signed [WIDTH_Y-1:0] y1,
  output logic signed [WIDTH_Y-1:0] y2,
  output logic signed [WIDTH_Y-1:0] y3,
  output logic signed [WIDTH_Y-1:0] y4,
  output logic signed [WIDTH_Y-1:0] y5,
  output logic signed [WIDTH_Y-1:0] y6,
  output logic signed [WIDTH_Y-1:0] y7
);

  localparam int IW  = WIDTH_X + 10;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IW-1:0] RND  = (SHIFT > 0) ? (IW'(1) <<< RSH) : '0;
  localparam logic signed [IW-1:0] YMAX = {{(IW-WIDTH_Y+1){1'b0}}, {(WIDTH_Y-1){1'b1}}};
  localparam logic signed [IW-1:0] YMIN = {{(IW-WIDTH_Y+1){1'b1}}, {(WIDTH_Y-1){1'b0}}};

  function automatic logic signed [IW-1:0] sext(input logic signed [WIDTH_X-1:0] v);
    return IW'(v);
  endfunction

  // Coefficient multiplies are called with literal constants, so each folds to a shift-add tree.
  function automatic logic signed [IW-1:0] cmul(input logic signed [IW-1:0] v, input int c);
    logic signed [IW-1:0] p;
    case (c)
      64:      p = v <<< 6;
      83:      p = (v <<< 6) + (v <<< 4) + (v <<< 1) + v;
      36:      p = (v <<< 5) + (v <<< 2);
      89:      p = (v <<< 6) + (v <<< 4) + (v <<< 3) + v;
      75:      p = (v <<< 6) + (v <<< 3) + (v <<< 1) + v;
      50:      p = (v <<< 5) + (v <<< 4) + (v <<< 1);
      18:      p = (v <<< 4) + (v <<< 1);
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic logic signed [WIDTH_Y-1:0] rnd_sat(input logic signed [IW-1:0] r);
    logic signed [IW-1:0] t;
    t = (r + RND) >>> SHIFT;
    if (t > YMAX)      return YMAX[WIDTH_Y-1:0];
    else if (t < YMIN) return YMIN[WIDTH_Y-1:0];
    else               return t[WIDTH_Y-1:0];
  endfunction

  logic                      en;
  logic signed [WIDTH_X-1:0] x_in [8];

  logic signed [WIDTH_X-1:0] x_p0 [8];
  logic                      mode_p0;
  logic                      vld_p0;

  logic signed [IW-1:0]      a, b, c, d;
  logic signed [IW-1:0]      e_c [4];
  logic signed [IW-1:0]      o_c [4];
  logic signed [IW-1:0]      e_p1 [4];
  logic signed [IW-1:0]      o_p1 [4];
  logic                      mode_p1;
  logic                      vld_p1;

  logic signed [IW-1:0]      r_c [8];
  logic signed [WIDTH_Y-1:0] y_c [8];
  logic signed [WIDTH_Y-1:0] y_p2 [8];
  logic                      vld_p2;

  assign en        = !vld_p2 | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p2;

  always_comb begin
    x_in[0] = x0; x_in[1] = x1; x_in[2] = x2; x_in[3] = x3;
    x_in[4] = x4; x_in[5] = x5; x_in[6] = x6; x_in[7] = x7;
  end

  // Stage 1: capture the input vector and its mode
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 8; i++) x_p0[i] <= '0;
      mode_p0 <= 1'b0;
      vld_p0  <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < 8; i++) x_p0[i] <= x_in[i];
      mode_p0 <= mode;
      vld_p0  <= in_valid;
    end
  end

  always_comb begin
    a = sext(x_p0[0]);
    b = mode_p0 ? sext(x_p0[1]) : sext(x_p0[2]);
    c = mode_p0 ? sext(x_p0[2]) : sext(x_p0[4]);
    d = mode_p0 ? sext(x_p0[3]) : sext(x_p0[6]);
    e_c[0] = cmul(a, 64) + cmul(c, 64) + cmul(b, 83) + cmul(d, 36);
    e_c[1] = cmul(a, 64) - cmul(c, 64) + cmul(b, 36) - cmul(d, 83);
    e_c[2] = cmul(a, 64) - cmul(c, 64) - cmul(b, 36) + cmul(d, 83);
    e_c[3] = cmul(a, 64) + cmul(c, 64) - cmul(b, 83) - cmul(d, 36);
    o_c[0] = cmul(sext(x_p0[1]), 89) + cmul(sext(x_p0[3]), 75)
           + cmul(sext(x_p0[5]), 50) + cmul(sext(x_p0[7]), 18);
    o_c[1] = cmul(sext(x_p0[1]), 75) - cmul(sext(x_p0[3]), 18)
           - cmul(sext(x_p0[5]), 89) - cmul(sext(x_p0[7]), 50);
    o_c[2] = cmul(sext(x_p0[1]), 50) - cmul(sext(x_p0[3]), 89)
           + cmul(sext(x_p0[5]), 18) + cmul(sext(x_p0[7]), 75);
    o_c[3] = cmul(sext(x_p0[1]), 18) - cmul(sext(x_p0[3]), 50)
           + cmul(sext(x_p0[5]), 75) - cmul(sext(x_p0[7]), 89);
    if (mode_p0) begin
      for (int k = 0; k < 4; k++) o_c[k] = '0;
    end
  end

  // Stage 2: register even and odd partial sums
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < 4; k++) begin
        e_p1[k] <= '0;
        o_p1[k] <= '0;
      end
      mode_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < 4; k++) begin
        e_p1[k] <= e_c[k];
        o_p1[k] <= o_c[k];
      end
      mode_p1 <= mode_p0;
      vld_p1  <= vld_p0;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      r_c[k]     = e_p1[k] + o_p1[k];
      r_c[7 - k] = e_p1[k] - o_p1[k];
    end
    for (int i = 0; i < 8; i++) y_c[i] = rnd_sat(r_c[i]);
    if (mode_p1) begin
      for (int i = 4; i < 8; i++) y_c[i] = '0;
    end
  end

  // Stage 3: butterfly, round, saturate into the output registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 8; i++) y_p2[i] <= '0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < 8; i++) y_p2[i] <= y_c[i];
      vld_p2 <= vld_p1;
    end
  end

  assign y0 = y_p2[0];
  assign y1 = y_p2[1];
  assign y2 = y_p2[2];
  assign y3 = y_p2[3];
  assign y4 = y_p2[4];
  assign y5 = y_p2[5];
  assign y6 = y_p2[6];
  assign y7 = y_p2[7];

endmodule
